// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//   Exhaustive stimulus and check engine for a small combinational gate network.
//   On start it walks {a,b,c,d} through every input vector. Each vector is held for
//   SETTLE_CYCLES clocks so the network's output can settle. The engine then samples
//   w_in_i for one clock and compares it with the golden table EXPECTED.
//   It reports a mismatch count, the lowest failing vector and a pass flag.
// Ports
//   clk                 rising-edge clock
//   rst_n               asynchronous active-low reset
//   start_i             one-cycle pulse; starts a sweep from idle or done
//   a_o, b_o, c_o, d_o  stimulus to the network under test; {a,b,c,d} = vector, a = MSB
//   w_in_i              output of the network under test
//   busy_o              high while a sweep is in progress
//   done_o              high once a sweep has finished; held until the next start or reset
//   pass_o              done with zero mismatches
//   err_count_o         number of mismatching vectors
//   first_fail_vec_o    lowest-numbered failing vector
//   first_fail_valid_o  first_fail_vec_o holds a real failure
module truth_table_sweeper #(
   parameter int unsigned          N_IN          = 4,
   parameter int unsigned          SETTLE_CYCLES = 4,
   parameter logic [2**N_IN-1:0]   EXPECTED      = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   output logic            a_o,
   output logic            b_o,
   output logic            c_o,
   output logic            d_o,
   input  logic            w_in_i,
   output logic            busy_o,
   output logic            done_o,
   output logic            pass_o,
   output logic [N_IN:0]   err_count_o,
   output logic [N_IN-1:0] first_fail_vec_o,
   output logic            first_fail_valid_o
);

   localparam int unsigned NVec = 2**N_IN;
   localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(SETTLE_CYCLES - 1);
   localparam logic [N_IN:0]   ErrMax  = (N_IN+1)'(NVec);

   typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

   state_e          state_q;
   logic [N_IN-1:0] vec_q;
   logic [CntW-1:0] cnt_q;
   logic [N_IN:0]   err_count_q;
   logic [N_IN-1:0] first_fail_vec_q;
   logic            first_fail_valid_q;
   logic            busy_q;
   logic            done_q;
   logic            pass_q;
   logic            mismatch;

   // Case inequality so an X or Z from the network counts as a failure.
   always_comb begin
      mismatch = (w_in_i !== EXPECTED[vec_q]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q            <= StIdle;
         vec_q              <= '0;
         cnt_q              <= '0;
         err_count_q        <= '0;
         first_fail_vec_q   <= '0;
         first_fail_valid_q <= 1'b0;
         busy_q             <= 1'b0;
         done_q             <= 1'b0;
         pass_q             <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               if (start_i) begin
                  vec_q              <= '0;
                  cnt_q              <= '0;
                  err_count_q        <= '0;
                  first_fail_vec_q   <= '0;
                  first_fail_valid_q <= 1'b0;
                  done_q             <= 1'b0;
                  pass_q             <= 1'b0;
                  busy_q             <= 1'b1;
                  state_q            <= StSettle;
               end
            end
            StSettle: begin
               if (cnt_q == CntLast) begin
                  state_q <= StSample;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StSample: begin
               if (mismatch) begin
                  if (err_count_q != ErrMax) begin
                     err_count_q <= err_count_q + 1'b1;
                  end
                  if (!first_fail_valid_q) begin
                     first_fail_vec_q   <= vec_q;
                     first_fail_valid_q <= 1'b1;
                  end
               end
               if (vec_q == '1) begin
                  // The last vector stays on the outputs while done is held.
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (err_count_q == '0) && !mismatch;
                  state_q <= StDone;
               end else begin
                  vec_q   <= vec_q + 1'b1;
                  cnt_q   <= '0;
                  state_q <= StSettle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign {a_o, b_o, c_o, d_o} = vec_q;
   assign busy_o               = busy_q;
   assign done_o               = done_q;
   assign pass_o               = pass_q;
   assign err_count_o          = err_count_q;
   assign first_fail_vec_o     = first_fail_vec_q;
   assign first_fail_valid_o   = first_fail_valid_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: one instance with golden table 16'h8000 (4-input AND).
// The network under test is modelled as an arbitrary 16-entry table, so each sweep can be
// made to produce any chosen set of mismatches.
module tb_truth_table_sweeper;

   localparam logic [15:0] Golden  = 16'h8000;
   localparam int          Settle  = 4;
   localparam int          DoneAt  = 16 * (Settle + 1);

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        a, b, c, d;
   logic        w_in;
   logic        busy, done, pass, ffvalid;
   logic [4:0]  err_count;
   logic [3:0]  ffvec;
   logic [15:0] net_tab = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Model of the network under test: a truth table chosen per sweep.
   assign w_in = net_tab[{a, b, c, d}];

   truth_table_sweeper #(
      .N_IN          (4),
      .SETTLE_CYCLES (Settle),
      .EXPECTED      (Golden)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .start_i            (start),
      .a_o                (a),
      .b_o                (b),
      .c_o                (c),
      .d_o                (d),
      .w_in_i             (w_in),
      .busy_o             (busy),
      .done_o             (done),
      .pass_o             (pass),
      .err_count_o        (err_count),
      .first_fail_vec_o   (ffvec),
      .first_fail_valid_o (ffvalid)
   );

   typedef struct {
      string       name;
      logic [15:0] tab;
      int          pulse_at;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int exp_vec(input int k);
      int v;
      v = k / (Settle + 1);
      return (v > 15) ? 15 : v;
   endfunction

   // Called at a negedge. Runs one sweep with the network modelled by tab; if pulse_at > 0
   // an extra start pulse is sampled at that clock while the sweep is busy.
   task automatic do_sweep(input string name, input logic [15:0] tab, input int pulse_at);
      logic [15:0] mism;
      int exp_err, exp_first, done_at, bad_vec, bad_busy;
      mism      = tab ^ Golden;
      exp_err   = 0;
      exp_first = 0;
      for (int i = 15; i >= 0; i--) begin
         if (mism[i]) begin
            exp_err++;
            exp_first = i;
         end
      end
      net_tab = tab;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({name, " start"}, int'({busy, done, pass, ffvalid, err_count, a, b, c, d}),
          int'({1'b1, 12'd0}));
      done_at  = -1;
      bad_vec  = 0;
      bad_busy = 0;
      for (int k = 1; k <= 200 && done_at < 0; k++) begin
         if (k == pulse_at) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         if (int'({a, b, c, d}) != exp_vec(k)) bad_vec++;
         if (done) done_at = k;
         else if (!busy) bad_busy++;
      end
      chk({name, " done_at"}, done_at, DoneAt);
      chk({name, " vec_seq"}, bad_vec, 0);
      chk({name, " busy"}, bad_busy, 0);
      chk({name, " err"}, int'(err_count), exp_err);
      chk({name, " ffvalid"}, int'(ffvalid), (exp_err != 0) ? 1 : 0);
      if (exp_err != 0) chk({name, " ffvec"}, int'(ffvec), exp_first);
      chk({name, " pass"}, int'(pass), (exp_err == 0) ? 1 : 0);
      repeat (3) @(negedge clk);
      chk({name, " hold"}, int'({busy, done, a, b, c, d}), int'({2'b01, 4'hF}));
   endtask

   vec_t tests[$];

   initial begin
      tests.push_back('{name: "and4",      tab: 16'h8000, pulse_at: 0});
      tests.push_back('{name: "tied0",     tab: 16'h0000, pulse_at: 0});
      tests.push_back('{name: "allfail",   tab: 16'h7FFF, pulse_at: 0});
      tests.push_back('{name: "busystart", tab: 16'h8000, pulse_at: 30});
      tests.push_back('{name: "pattern",   tab: 16'hA5A5, pulse_at: 0});
      tests.push_back('{name: "vec0",      tab: 16'h8001, pulse_at: 77});

      // Reset held with start toggling: everything stays at zero.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         start = ~start;
      end
      chk("reset", int'({busy, done, pass, ffvalid, err_count, ffvec, a, b, c, d}), 0);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("idle", int'({busy, done, pass, ffvalid, err_count, a, b, c, d}), 0);

      foreach (tests[i]) do_sweep(tests[i].name, tests[i].tab, tests[i].pulse_at);

      for (int r = 0; r < 6; r++) begin
         do_sweep($sformatf("rand%0d", r), 16'($urandom_range(0, 65535)),
                  (r % 2 == 1) ? int'($urandom_range(1, DoneAt - 1)) : 0);
      end

      // Abort mid-sweep: reset wipes any partial result.
      net_tab = 16'h0000;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (40) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst mid-sweep", int'({busy, done, pass, ffvalid, err_count, ffvec, a, b, c, d}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst idle", int'({busy, done, err_count}), 0);
      do_sweep("post-reset", Golden, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
